commit_progress_monitor: RTL and testbench

- Synthesizable successor to the bench-side commit accounting and end-of-run detection logic.
- Sits beside the core and observes the per-lane commit signals from the commit stage.
- Counts cycles, committed RISC-V ops and micro-ops, and tracks the last committed PC.
- Ends a run on PC goal, cycle limit or commit deadlock, and latches the cause so on-chip, FPGA and simulation runs share one termination mechanism.

---
 rtl/commit_progress_monitor_pkg.sv | 21 ++
 rtl/commit_progress_monitor_if.sv | 32 +++
 rtl/commit_progress_monitor_lane_reducer.sv | 39 +++
 rtl/commit_progress_monitor.sv | 124 ++++++++++++
 tb/tb_commit_progress_monitor.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_progress_monitor_pkg.sv
// Shared types for the commit progress monitor: FSM states, termination causes
// and the default deadlock threshold.
package commit_progress_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } MonitorState;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    PC_GOAL    = 3'd1,
    MAX_CYCLES = 3'd2,
    DEADLOCK   = 3'd3,
    ABORT      = 3'd4
  } MonitorDoneReason;

  localparam int unsigned DEFAULT_STALL_LIMIT = 4096;

endpackage

// File: rtl/commit_progress_monitor_if.sv
// Observation bundle between the commit stage / run controller and the monitor.
interface commit_progress_monitor_if #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned COUNT_WIDTH  = 48
);
  logic                             start;
  logic                             abort;
  logic [COMMIT_WIDTH-1:0]          commit;
  logic [COMMIT_WIDTH-1:0]          commitMidZero;
  logic [COMMIT_WIDTH*PC_WIDTH-1:0] commitPC;
  logic [PC_WIDTH-1:0]              pcGoal;
  logic                             pcGoalEnable;
  logic [COUNT_WIDTH-1:0]           maxCycles;
  logic                             running;
  logic                             done;
  logic [2:0]                       doneReason;
  logic [COUNT_WIDTH-1:0]           cycleCount;
  logic [COUNT_WIDTH-1:0]           numRiscvOps;
  logic [COUNT_WIDTH-1:0]           numMicroOps;
  logic [PC_WIDTH-1:0]              lastCommittedPC;

  modport slave (
    input  start, abort, commit, commitMidZero, commitPC, pcGoal, pcGoalEnable, maxCycles,
    output running, done, doneReason, cycleCount, numRiscvOps, numMicroOps, lastCommittedPC
  );

  modport master (
    output start, abort, commit, commitMidZero, commitPC, pcGoal, pcGoalEnable, maxCycles,
    input  running, done, doneReason, cycleCount, numRiscvOps, numMicroOps, lastCommittedPC
  );
endinterface

// File: rtl/commit_progress_monitor_lane_reducer.sv
// Collapses the per-lane commit signals into counts, the youngest committed PC
// and a goal-match flag so the FSM does not depend on the lane count.
module commit_lane_reducer #(
  parameter int unsigned COMMIT_WIDTH   = 2,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned GOAL_CMP_WIDTH = 32,
  localparam int unsigned CNT_W         = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0]          commit_i,
  input  logic [COMMIT_WIDTH-1:0]          commitMidZero_i,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] commitPC_i,
  input  logic [PC_WIDTH-1:0]              pcGoal_i,
  output logic [CNT_W-1:0]                 uopCount_o,
  output logic [CNT_W-1:0]                 ropCount_o,
  output logic                             anyCommit_o,
  output logic [PC_WIDTH-1:0]              lastPC_o,
  output logic                             goalHit_o
);
  localparam logic [PC_WIDTH-1:0] GOAL_MASK = {PC_WIDTH{1'b1}} >> (PC_WIDTH - GOAL_CMP_WIDTH);

  always_comb begin
    uopCount_o  = '0;
    ropCount_o  = '0;
    anyCommit_o = 1'b0;
    lastPC_o    = '0;
    goalHit_o   = 1'b0;
    // Ascending scan: the last committing lane seen is the highest-index one.
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_i[i]) begin
        uopCount_o  = uopCount_o + CNT_W'(1);
        if (commitMidZero_i[i]) ropCount_o = ropCount_o + CNT_W'(1);
        anyCommit_o = 1'b1;
        lastPC_o    = commitPC_i[i*PC_WIDTH +: PC_WIDTH];
        if (((commitPC_i[i*PC_WIDTH +: PC_WIDTH] ^ pcGoal_i) & GOAL_MASK) == '0)
          goalHit_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/commit_progress_monitor.sv
// Run-level commit accounting and end-of-run detection (PC goal, cycle limit,
// commit deadlock, abort) with a latched termination cause.
module commit_progress_monitor
  import commit_progress_monitor_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH   = 2,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned GOAL_CMP_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH    = 48,
  parameter int unsigned STALL_LIMIT    = DEFAULT_STALL_LIMIT
) (
  input  logic                      clk,
  input  logic                      negResetIn,
  commit_progress_monitor_if.slave  mon
);
  localparam int unsigned CNT_W   = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

  MonitorState            state_q, state_d;
  MonitorDoneReason       reason_q, reason_d;
  logic [COUNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [COUNT_WIDTH-1:0] rops_q, rops_d;
  logic [COUNT_WIDTH-1:0] uops_q, uops_d;
  logic [PC_WIDTH-1:0]    lpc_q, lpc_d;
  logic [STALL_W-1:0]     stall_q, stall_d;

  logic [CNT_W-1:0]       uop_cnt, rop_cnt;
  logic                   any_commit, goal_hit, cycle_limit_hit;
  logic [PC_WIDTH-1:0]    lane_pc;

  commit_lane_reducer #(
    .COMMIT_WIDTH  (COMMIT_WIDTH),
    .PC_WIDTH      (PC_WIDTH),
    .GOAL_CMP_WIDTH(GOAL_CMP_WIDTH)
  ) u_reducer (
    .commit_i       (mon.commit),
    .commitMidZero_i(mon.commitMidZero),
    .commitPC_i     (mon.commitPC),
    .pcGoal_i       (mon.pcGoal),
    .uopCount_o     (uop_cnt),
    .ropCount_o     (rop_cnt),
    .anyCommit_o    (any_commit),
    .lastPC_o       (lane_pc),
    .goalHit_o      (goal_hit)
  );

  function automatic logic [COUNT_WIDTH-1:0] sat_add(logic [COUNT_WIDTH-1:0] a, logic [CNT_W-1:0] b);
    logic [COUNT_WIDTH:0] s;
    s = {1'b0, a} + (COUNT_WIDTH + 1)'(b);
    return s[COUNT_WIDTH] ? '1 : s[COUNT_WIDTH-1:0];
  endfunction

  // One bit wider so a saturated cycle count still compares correctly.
  assign cycle_limit_hit = (mon.maxCycles != '0) &&
                           (({1'b0, cyc_q} + (COUNT_WIDTH + 1)'(1)) >= {1'b0, mon.maxCycles});

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    cyc_d    = cyc_q;
    rops_d   = rops_q;
    uops_d   = uops_q;
    lpc_d    = lpc_q;
    stall_d  = stall_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (mon.start) begin
          state_d  = RUN;
          reason_d = NONE;
          cyc_d    = '0;
          rops_d   = '0;
          uops_d   = '0;
          lpc_d    = '0;
          stall_d  = '0;
        end
      end
      RUN: begin
        cyc_d  = sat_add(cyc_q, CNT_W'(1));
        uops_d = sat_add(uops_q, uop_cnt);
        rops_d = sat_add(rops_q, rop_cnt);
        if (any_commit) begin
          lpc_d   = lane_pc;
          stall_d = '0;
        end else if (stall_q != STALL_W'(STALL_LIMIT)) begin
          stall_d = stall_q + STALL_W'(1);
        end
        if (mon.abort)                                reason_d = ABORT;
        else if (mon.pcGoalEnable && goal_hit)        reason_d = PC_GOAL;
        else if (stall_d == STALL_W'(STALL_LIMIT))    reason_d = DEADLOCK;
        else if (cycle_limit_hit)                     reason_d = MAX_CYCLES;
        if (reason_d != NONE) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      state_q  <= IDLE;
      reason_q <= NONE;
      cyc_q    <= '0;
      rops_q   <= '0;
      uops_q   <= '0;
      lpc_q    <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      cyc_q    <= cyc_d;
      rops_q   <= rops_d;
      uops_q   <= uops_d;
      lpc_q    <= lpc_d;
      stall_q  <= stall_d;
    end
  end

  assign mon.running         = (state_q == RUN);
  assign mon.done            = (state_q == DONE);
  assign mon.doneReason      = reason_q;
  assign mon.cycleCount      = cyc_q;
  assign mon.numRiscvOps     = rops_q;
  assign mon.numMicroOps     = uops_q;
  assign mon.lastCommittedPC = lpc_q;
endmodule

// File: tb/tb_commit_progress_monitor.sv
// Self-checking bench: two monitor configurations share one stimulus stream and
// are compared against directed expectations and a per-cycle reference model.
module tb_commit_progress_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_s = 1'b0, abort_s = 1'b0, goalen_s = 1'b0;
  logic [1:0]  commit_s = '0, mz_s = '0;
  logic [63:0] pc_s = '0;
  logic [31:0] goal_s = '0;
  logic [47:0] maxc_s = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // A: 16-bit goal compare, wide counters, stall limit 8.  B: full goal compare, 4-bit counters, stall limit 5.
  commit_progress_monitor_if #(.COMMIT_WIDTH(2), .PC_WIDTH(32), .COUNT_WIDTH(48)) ifA ();
  commit_progress_monitor_if #(.COMMIT_WIDTH(2), .PC_WIDTH(32), .COUNT_WIDTH(4))  ifB ();

  commit_progress_monitor #(.COMMIT_WIDTH(2), .PC_WIDTH(32), .GOAL_CMP_WIDTH(16),
                            .COUNT_WIDTH(48), .STALL_LIMIT(8))
    dutA (.clk(clk), .negResetIn(rst_n), .mon(ifA));
  commit_progress_monitor #(.COMMIT_WIDTH(2), .PC_WIDTH(32), .GOAL_CMP_WIDTH(32),
                            .COUNT_WIDTH(4), .STALL_LIMIT(5))
    dutB (.clk(clk), .negResetIn(rst_n), .mon(ifB));

  assign ifA.start = start_s;  assign ifB.start = start_s;
  assign ifA.abort = abort_s;  assign ifB.abort = abort_s;
  assign ifA.commit = commit_s;  assign ifB.commit = commit_s;
  assign ifA.commitMidZero = mz_s;  assign ifB.commitMidZero = mz_s;
  assign ifA.commitPC = pc_s;  assign ifB.commitPC = pc_s;
  assign ifA.pcGoal = goal_s;  assign ifB.pcGoal = goal_s;
  assign ifA.pcGoalEnable = goalen_s;  assign ifB.pcGoalEnable = goalen_s;
  assign ifA.maxCycles = maxc_s;  assign ifB.maxCycles = maxc_s[3:0];

  // Reference model: st 0=idle 1=run 2=done.
  typedef struct {
    int              st;
    logic [2:0]      rsn;
    longint unsigned cyc, rops, uops;
    logic [31:0]     lpc;
    int              stall;
  } mdl_t;
  mdl_t mA, mB;

  function automatic mdl_t mstep(mdl_t m, int cw, int gw, int lim, longint unsigned maxc);
    longint unsigned top = (64'd1 << cw) - 1;
    longint unsigned old_cyc;
    logic [31:0] mask = 32'hFFFF_FFFF >> (32 - gw);
    int nu = 0, nr = 0;
    bit hit = 0, anyc = 0;
    if (m.st != 1) begin
      if (start_s) begin
        m = '{default: 0};
        m.st = 1;
      end
      return m;
    end
    for (int i = 0; i < 2; i++) begin
      if (commit_s[i]) begin
        nu++;
        if (mz_s[i]) nr++;
        anyc = 1;
        m.lpc = pc_s[i*32 +: 32];
        if (((pc_s[i*32 +: 32] ^ goal_s) & mask) == 0) hit = 1;
      end
    end
    old_cyc = m.cyc;
    m.cyc  = (m.cyc + 1 > top) ? top : m.cyc + 1;
    m.uops = (m.uops + nu > top) ? top : m.uops + nu;
    m.rops = (m.rops + nr > top) ? top : m.rops + nr;
    if (anyc) m.stall = 0;
    else if (m.stall < lim) m.stall++;
    if (abort_s)                           m.rsn = 3'd4;
    else if (goalen_s && hit)              m.rsn = 3'd1;
    else if (!anyc && m.stall == lim)      m.rsn = 3'd3;
    else if (maxc != 0 && old_cyc + 1 >= maxc) m.rsn = 3'd2;
    if (m.rsn != 0) m.st = 2;
    return m;
  endfunction

  task automatic tick();
    mA = mstep(mA, 48, 16, 8, maxc_s);
    mB = mstep(mB, 4, 32, 5, longint'(maxc_s[3:0]));
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run();
    commit_s = '0;
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  task automatic test_reset();
    mA = '{default: 0};
    mB = '{default: 0};
    #17;
    n_checks++; if (ifA.running !== 1'b0 || ifA.done !== 1'b0) begin n_fail++; $display("FAIL reset_state: running=%b done=%b expected 0 0", ifA.running, ifA.done); end
    n_checks++; if (ifA.doneReason !== 3'd0) begin n_fail++; $display("FAIL reset_reason: got %0d expected 0", ifA.doneReason); end
    n_checks++; if (ifA.cycleCount !== 48'd0 || ifA.numMicroOps !== 48'd0 || ifA.numRiscvOps !== 48'd0 || ifA.lastCommittedPC !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: cyc=%0d uops=%0d rops=%0d pc=%h expected all 0", ifA.cycleCount, ifA.numMicroOps, ifA.numRiscvOps, ifA.lastCommittedPC); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    commit_s = 2'b11;
    tick();
    n_checks++; if (ifA.running !== 1'b0 || ifA.cycleCount !== 48'd0) begin n_fail++; $display("FAIL idle_hold: running=%b cyc=%0d expected 0 0", ifA.running, ifA.cycleCount); end
    commit_s = '0;
  endtask

  task automatic test_basic();
    abort_s = 1'b1; start_s = 1'b1; commit_s = 2'b11;
    tick();
    abort_s = 1'b0; start_s = 1'b0;
    n_checks++; if (ifA.running !== 1'b1 || ifA.numMicroOps !== 48'd0) begin n_fail++; $display("FAIL start_entry: running=%b uops=%0d expected 1 0", ifA.running, ifA.numMicroOps); end
    mz_s = 2'b01;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (ifA.cycleCount !== 48'd10) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 10", ifA.cycleCount); end
    n_checks++; if (ifA.numMicroOps !== 48'd20) begin n_fail++; $display("FAIL basic_uops: got %0d expected 20", ifA.numMicroOps); end
    n_checks++; if (ifA.numRiscvOps !== 48'd10) begin n_fail++; $display("FAIL basic_rops: got %0d expected 10", ifA.numRiscvOps); end
    n_checks++; if (ifA.running !== 1'b1) begin n_fail++; $display("FAIL basic_running: got %b expected 1", ifA.running); end
  endtask

  task automatic test_goal();
    goal_s = 32'h0000_1234; goalen_s = 1'b1; mz_s = 2'b11;
    begin_run();
    pc_s = {32'h0, 32'h0000_0100};
    commit_s = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    commit_s = 2'b10;
    pc_s = {32'h8000_1234, 32'h0000_0100};
    tick();
    n_checks++; if (ifA.done !== 1'b1 || ifA.doneReason !== 3'd1) begin n_fail++; $display("FAIL goal_reason: done=%b reason=%0d expected 1 1", ifA.done, ifA.doneReason); end
    n_checks++; if (ifA.cycleCount !== 48'd5 || ifA.numMicroOps !== 48'd5 || ifA.numRiscvOps !== 48'd5) begin
      n_fail++; $display("FAIL goal_counts: cyc=%0d uops=%0d rops=%0d expected 5 5 5", ifA.cycleCount, ifA.numMicroOps, ifA.numRiscvOps); end
    n_checks++; if (ifA.lastCommittedPC !== 32'h8000_1234) begin n_fail++; $display("FAIL goal_pc: got %h expected 80001234", ifA.lastCommittedPC); end
    commit_s = 2'b11; abort_s = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    abort_s = 1'b0;
    n_checks++; if (ifA.cycleCount !== 48'd5 || ifA.doneReason !== 3'd1 || ifA.done !== 1'b1) begin
      n_fail++; $display("FAIL done_hold: cyc=%0d reason=%0d done=%b expected 5 1 1", ifA.cycleCount, ifA.doneReason, ifA.done); end
    goalen_s = 1'b0; commit_s = '0;
  endtask

  task automatic test_max_cycles();
    int n;
    maxc_s = 48'd100;
    begin_run();
    commit_s = 2'b11; pc_s = {32'h40, 32'h20};
    n = 0;
    while (!ifA.done && n < 150) begin tick(); n++; end
    n_checks++; if (ifA.done !== 1'b1 || n != 100) begin n_fail++; $display("FAIL maxcyc_latency: done=%b cycles=%0d expected 1 100", ifA.done, n); end
    n_checks++; if (ifA.doneReason !== 3'd2 || ifA.cycleCount !== 48'd100) begin n_fail++; $display("FAIL maxcyc_result: reason=%0d cyc=%0d expected 2 100", ifA.doneReason, ifA.cycleCount); end
    maxc_s = '0;
    begin_run();
    commit_s = '0;
    n = 0;
    while (!ifA.done && n < 50) begin tick(); n++; end
    n_checks++; if (ifA.done !== 1'b1 || n != 8 || ifA.doneReason !== 3'd3 || ifA.cycleCount !== 48'd8) begin
      n_fail++; $display("FAIL deadlock: done=%b cycles=%0d reason=%0d cyc=%0d expected 1 8 3 8", ifA.done, n, ifA.doneReason, ifA.cycleCount); end
  endtask

  task automatic test_priority();
    goal_s = 32'h0000_1234; goalen_s = 1'b1; maxc_s = 48'd3;
    for (int pass = 0; pass < 2; pass++) begin
      begin_run();
      commit_s = 2'b01; pc_s = {32'h0, 32'h100};
      tick(); tick();
      pc_s = {32'h0, 32'h1234};
      abort_s = (pass == 0);
      tick();
      abort_s = 1'b0;
      n_checks++; if (ifA.doneReason !== (pass == 0 ? 3'd4 : 3'd1) || ifA.cycleCount !== 48'd3) begin
        n_fail++; $display("FAIL priority_%0d: reason=%0d cyc=%0d expected %0d 3", pass, ifA.doneReason, ifA.cycleCount, pass == 0 ? 4 : 1); end
    end
    goalen_s = 1'b0; maxc_s = 48'd8;
    begin_run();
    commit_s = '0;
    for (int i = 0; i < 8; i++) tick();
    n_checks++; if (ifA.doneReason !== 3'd3 || ifA.done !== 1'b1) begin n_fail++; $display("FAIL deadlock_over_max: reason=%0d done=%b expected 3 1", ifA.doneReason, ifA.done); end
    maxc_s = '0;
  endtask

  task automatic test_noncontig();
    begin_run();
    mz_s = 2'b00; commit_s = 2'b10; pc_s = {32'h200, 32'h100};
    tick();
    n_checks++; if (ifA.lastCommittedPC !== 32'h200 || ifA.numMicroOps !== 48'd1 || ifA.numRiscvOps !== 48'd0) begin
      n_fail++; $display("FAIL noncontig: pc=%h uops=%0d rops=%0d expected 200 1 0", ifA.lastCommittedPC, ifA.numMicroOps, ifA.numRiscvOps); end
    commit_s = 2'b01; pc_s = {32'h200, 32'h300};
    tick();
    commit_s = 2'b00; pc_s = {32'h999, 32'h888};
    tick();
    n_checks++; if (ifA.lastCommittedPC !== 32'h300 || ifA.numMicroOps !== 48'd2) begin
      n_fail++; $display("FAIL pc_hold: pc=%h uops=%0d expected 300 2", ifA.lastCommittedPC, ifA.numMicroOps); end
  endtask

  task automatic test_saturation();
    begin_run();
    commit_s = 2'b11; mz_s = 2'b11; pc_s = {32'h10, 32'h20};
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (ifB.cycleCount !== 4'd15 || ifB.numMicroOps !== 4'd15 || ifB.numRiscvOps !== 4'd15 || ifB.running !== 1'b1) begin
      n_fail++; $display("FAIL saturate: cyc=%0d uops=%0d rops=%0d running=%b expected 15 15 15 1", ifB.cycleCount, ifB.numMicroOps, ifB.numRiscvOps, ifB.running); end
    n_checks++; if (ifA.numMicroOps !== 48'd40) begin n_fail++; $display("FAIL wide_no_sat: got %0d expected 40", ifA.numMicroOps); end
  endtask

  task automatic test_reset_midrun();
    begin_run();
    commit_s = 2'b11;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    mA = '{default: 0}; mB = '{default: 0};
    n_checks++; if (ifA.running !== 1'b0 || ifA.done !== 1'b0 || ifA.cycleCount !== 48'd0 || ifA.numMicroOps !== 48'd0 || ifA.lastCommittedPC !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: running=%b done=%b cyc=%0d uops=%0d pc=%h expected all 0", ifA.running, ifA.done, ifA.cycleCount, ifA.numMicroOps, ifA.lastCommittedPC); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (ifA.cycleCount !== 48'd3 || ifA.numMicroOps !== 48'd6) begin
      n_fail++; $display("FAIL restart: cyc=%0d uops=%0d expected 3 6", ifA.cycleCount, ifA.numMicroOps); end
  endtask

  task automatic test_random();
    logic [31:0] lane [2];
    for (int run = 0; run < 4; run++) begin
      goal_s   = $urandom;
      goalen_s = ($urandom_range(0, 2) != 0);
      maxc_s   = ($urandom_range(0, 1) == 0) ? 48'd0 : 48'($urandom_range(10, 60));
      begin_run();
      for (int c = 0; c < 150; c++) begin
        commit_s = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) commit_s = '0;
        mz_s = 2'($urandom_range(0, 3));
        for (int l = 0; l < 2; l++) begin
          case ($urandom_range(0, 15))
            0:       lane[l] = goal_s;
            1:       lane[l] = {16'($urandom), goal_s[15:0]};
            default: lane[l] = $urandom;
          endcase
        end
        pc_s = {lane[1], lane[0]};
        abort_s = ($urandom_range(0, 39) == 0);
        start_s = ($urandom_range(0, 9) == 0);
        tick();
        n_checks++; if (ifA.cycleCount !== mA.cyc[47:0] || ifA.numMicroOps !== mA.uops[47:0] || ifA.numRiscvOps !== mA.rops[47:0]) begin
          n_fail++; $display("FAIL rand_countsA: cyc=%0d uops=%0d rops=%0d expected %0d %0d %0d", ifA.cycleCount, ifA.numMicroOps, ifA.numRiscvOps, mA.cyc, mA.uops, mA.rops); end
        n_checks++; if (ifA.lastCommittedPC !== mA.lpc || ifA.doneReason !== mA.rsn || ifA.running !== (mA.st == 1) || ifA.done !== (mA.st == 2)) begin
          n_fail++; $display("FAIL rand_stateA: pc=%h reason=%0d run=%b done=%b expected %h %0d st=%0d", ifA.lastCommittedPC, ifA.doneReason, ifA.running, ifA.done, mA.lpc, mA.rsn, mA.st); end
        n_checks++; if (ifB.cycleCount !== mB.cyc[3:0] || ifB.numMicroOps !== mB.uops[3:0] || ifB.numRiscvOps !== mB.rops[3:0] || ifB.lastCommittedPC !== mB.lpc) begin
          n_fail++; $display("FAIL rand_countsB: cyc=%0d uops=%0d rops=%0d pc=%h expected %0d %0d %0d %h", ifB.cycleCount, ifB.numMicroOps, ifB.numRiscvOps, ifB.lastCommittedPC, mB.cyc, mB.uops, mB.rops, mB.lpc); end
        n_checks++; if (ifB.doneReason !== mB.rsn || ifB.running !== (mB.st == 1) || ifB.done !== (mB.st == 2)) begin
          n_fail++; $display("FAIL rand_stateB: reason=%0d run=%b done=%b expected %0d st=%0d", ifB.doneReason, ifB.running, ifB.done, mB.rsn, mB.st); end
      end
      abort_s = 1'b0; start_s = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_goal();
    test_max_cycles();
    test_priority();
    test_noncontig();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
